// File: rtl/tbuf_bus_if.sv
// Control, configuration and status bundle of the tbuf_bus routing segment.
// The tristate bus itself stays a plain port of tbuf_bus.
interface tbuf_bus_if #(
    parameter int WIDTH = 1,
    parameter int N_DRV = 4,
    parameter int CNT_W = 8
);
    logic                   cfg_shift_en;
    logic                   cfg_in;
    logic                   cfg_out;
    logic                   cfg_commit;
    logic [N_DRV*WIDTH-1:0] drv_data;
    logic [N_DRV-1:0]       drv_oe;
    logic                   bus_valid;
    logic                   contention;
    logic                   err_sticky;
    logic                   err_clr;
    logic [CNT_W-1:0]       contention_cnt;

    modport master (
        output cfg_shift_en, cfg_in, cfg_commit, drv_data, drv_oe, err_clr,
        input  cfg_out, bus_valid, contention, err_sticky, contention_cnt
    );

    modport slave (
        input  cfg_shift_en, cfg_in, cfg_commit, drv_data, drv_oe, err_clr,
        output cfg_out, bus_valid, contention, err_sticky, contention_cnt
    );
endinterface

// File: rtl/tbuf_bus.sv
// Multi-driver tristate bus segment with shadow/commit serial configuration and
// contention monitoring. Optional bus keeper: define TBUF_BUS_KEEPER_EN.
module tbuf_bus #(
    parameter int WIDTH = 1,
    parameter int N_DRV = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    tbuf_bus_if.slave        bif,
    output tri [WIDTH-1:0]   bus
);
    localparam int L  = 2 * N_DRV;
    localparam int PW = $clog2(N_DRV + 1);

    logic [L-1:0]     shadow_q, shadow_d;
    logic [L-1:0]     active_q, active_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_DRV-1:0] eff;
    logic [PW-1:0]    n_en;
    logic             contention;

    // Bit 2i is driver i's enable, bit 2i+1 selects gating by drv_oe.
    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        eff  = '0;
        n_en = '0;
        for (int i = 0; i < N_DRV; i++) begin
            eff[i] = active_q[2*i] & (active_q[2*i+1] ? bif.drv_oe[i] : 1'b1);
            n_en   = n_en + PW'(eff[i]);
        end
    end

    assign contention     = (n_en >= PW'(2));
    assign bif.contention = contention;
    assign bif.bus_valid  = (n_en == PW'(1));
    assign bif.cfg_out    = shadow_q[L-1];
    assign bif.err_sticky = err_q;
    assign bif.contention_cnt = cnt_q;

    for (genvar i = 0; i < N_DRV; i++) begin : g_drv
        assign bus = eff[i] ? bif.drv_data[i*WIDTH +: WIDTH] : {WIDTH{1'bz}};
    end

    // Commit samples the pre-shift shadow, so a same-cycle shift is not lost.
    always_comb begin
        shadow_d = bif.cfg_shift_en ? {shadow_q[L-2:0], bif.cfg_in} : shadow_q;
        active_d = bif.cfg_commit ? shadow_q : active_q;

        err_d = err_q;
        cnt_d = cnt_q;
        if (bif.err_clr) begin
            err_d = contention;
            cnt_d = contention ? CNT_W'(1) : '0;
        end else if (contention) begin
            err_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef TBUF_BUS_KEEPER_EN
    logic [WIDTH-1:0] keeper_q, keeper_d;
    logic [WIDTH-1:0] sel_data;

    // With exactly one driver on, the OR of masked slices is that driver's data.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_DRV; i++) begin
            if (eff[i]) begin
                sel_data = sel_data | bif.drv_data[i*WIDTH +: WIDTH];
            end
        end
        keeper_d = bif.bus_valid ? sel_data : keeper_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keeper_q <= '0;
        end else begin
            keeper_q <= keeper_d;
        end
    end

    assign bus = (n_en == '0) ? keeper_q : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_tbuf_bus.sv
// Directed bench for tbuf_bus with a bit-queue behavioural model checked every cycle.
module tb_tbuf_bus;
    localparam int W    = 4;
    localparam int N    = 4;
    localparam int C    = 2;
    localparam int L    = 2 * N;
    localparam int CMAX = (1 << C) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    wire  [W-1:0] bus;
    bit           check_en = 1'b0;
    int           total = 0;
    int           bad = 0;

    tbuf_bus_if #(.WIDTH(W), .N_DRV(N), .CNT_W(C)) bif ();

    tbuf_bus #(.WIDTH(W), .N_DRV(N), .CNT_W(C)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: shadow is a bit queue whose front is the chain MSB (the cfg_out bit).
    bit         sh[$];
    bit         m_en[N];
    bit         m_mode[N];
    bit         m_err;
    int         m_cnt;
    logic [W-1:0] m_keep;

    function automatic int n_on();
        int n = 0;
        for (int i = 0; i < N; i++)
            if (m_en[i] && (!m_mode[i] || bif.drv_oe[i])) n++;
        return n;
    endfunction

    function automatic logic [W-1:0] on_data();
        logic [W-1:0] d = '0;
        for (int i = 0; i < N; i++)
            if (m_en[i] && (!m_mode[i] || bif.drv_oe[i])) d = bif.drv_data[i*W +: W];
        return d;
    endfunction

    always @(posedge clk) begin
        int n;
        n = n_on();
        if (rst) begin
            sh = {};
            for (int k = 0; k < L; k++) sh.push_back(1'b0);
            for (int i = 0; i < N; i++) begin m_en[i] = 0; m_mode[i] = 0; end
            m_err  = 0;
            m_cnt  = 0;
            m_keep = '0;
        end else begin
            if (n == 1) m_keep = on_data();
            if (bif.err_clr) begin
                m_err = (n >= 2);
                m_cnt = (n >= 2) ? 1 : 0;
            end else if (n >= 2) begin
                m_err = 1;
                if (m_cnt < CMAX) m_cnt++;
            end
            if (bif.cfg_commit)
                for (int i = 0; i < N; i++) begin
                    m_en[i]   = sh[L-1-2*i];
                    m_mode[i] = sh[L-2-2*i];
                end
            if (bif.cfg_shift_en) begin
                void'(sh.pop_front());
                sh.push_back(bif.cfg_in);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int n;
            n = n_on();
            check("cmp_bus_valid", 32'(bif.bus_valid), 32'(n == 1));
            check("cmp_contention", 32'(bif.contention), 32'(n >= 2));
            check("cmp_cfg_out", 32'(bif.cfg_out), 32'(sh[0]));
            check("cmp_err_sticky", 32'(bif.err_sticky), 32'(m_err));
            check("cmp_cnt", 32'(bif.contention_cnt), 32'(m_cnt));
            if (n == 1) check("cmp_bus", 32'(bus), 32'(on_data()));
`ifdef TBUF_BUS_KEEPER_EN
            if (n == 0) check("cmp_keeper", 32'(bus), 32'(m_keep));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #2;
    endtask

    // Shifts v MSB-first; when chk is set, cfg_out must replay old MSB-first.
    task automatic shift_cfg(input logic [7:0] v, input logic [7:0] old, input bit chk);
        for (int k = 7; k >= 0; k--) begin
            bif.cfg_shift_en = 1'b1;
            bif.cfg_in       = v[k];
            if (chk) check("cfg_out_order", 32'(bif.cfg_out), 32'(old[k]));
            tick();
        end
        bif.cfg_shift_en = 1'b0;
        bif.cfg_in       = 1'b0;
    endtask

    task automatic commit();
        bif.cfg_commit = 1'b1;
        tick();
        bif.cfg_commit = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < L; k++) sh.push_back(1'b0);
        bif.cfg_shift_en = 1'b0;
        bif.cfg_in       = 1'b0;
        bif.cfg_commit   = 1'b0;
        bif.drv_data     = {4'hC, 4'h7, 4'h5, 4'hA};
        bif.drv_oe       = '0;
        bif.err_clr      = 1'b0;

        tick();
        check_en = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst_bus_valid", 32'(bif.bus_valid), 32'd0);
        check("rst_contention", 32'(bif.contention), 32'd0);
        check("rst_cfg_out", 32'(bif.cfg_out), 32'd0);
        check("rst_cnt", 32'(bif.contention_cnt), 32'd0);
        check("rst_err", 32'(bif.err_sticky), 32'd0);

        // Driver 0 always on; nothing drives until the commit lands.
        shift_cfg(8'b0000_0001, 8'h00, 1'b1);
        settle();
        check("precommit_valid", 32'(bif.bus_valid), 32'd0);
        commit();
        settle();
        check("commit_bus", 32'(bus), 32'hA);
        check("commit_valid", 32'(bif.bus_valid), 32'd1);

        // Shift without commit leaves the active config alone.
        shift_cfg(8'b0000_1111, 8'b0000_0001, 1'b1);
        settle();
        check("noncommit_bus", 32'(bus), 32'hA);

        // Same-cycle shift and commit: active takes 0000_1111, both drivers gated by oe.
        bif.cfg_shift_en = 1'b1;
        bif.cfg_in       = 1'b0;
        bif.cfg_commit   = 1'b1;
        tick();
        bif.cfg_shift_en = 1'b0;
        bif.cfg_commit   = 1'b0;
        settle();
        check("shiftcommit_valid", 32'(bif.bus_valid), 32'd0);
        check("shiftcommit_cfg_out", 32'(bif.cfg_out), 32'd0);
        bif.drv_oe = 4'b0010;
        settle();
        check("oe_bus", 32'(bus), 32'h5);

        // Three contention cycles, then clear.
        bif.drv_oe = 4'b0011;
        settle();
        check("cont_flag", 32'(bif.contention), 32'd1);
        tick(); tick(); tick();
        bif.drv_oe  = 4'b0000;
        bif.err_clr = 1'b1;
        settle();
        check("cont_err", 32'(bif.err_sticky), 32'd1);
        check("cont_cnt3", 32'(bif.contention_cnt), 32'd3);
        tick();
        bif.err_clr = 1'b0;
        settle();
        check("clr_err", 32'(bif.err_sticky), 32'd0);
        check("clr_cnt", 32'(bif.contention_cnt), 32'd0);

        // Saturation, then clear colliding with contention.
        bif.drv_oe = 4'b0011;
        repeat (6) tick();
        settle();
        check("sat_cnt", 32'(bif.contention_cnt), 32'(CMAX));
        bif.err_clr = 1'b1;
        tick();
        bif.err_clr = 1'b0;
        bif.drv_oe  = 4'b0000;
        settle();
        check("clrcoll_cnt", 32'(bif.contention_cnt), 32'd1);
        check("clrcoll_err", 32'(bif.err_sticky), 32'd1);

        // Reset during a partial shift; the shift enable is still high.
        bif.cfg_shift_en = 1'b1;
        bif.cfg_in       = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst              = 1'b0;
        bif.cfg_shift_en = 1'b0;
        bif.cfg_in       = 1'b0;
        settle();
        check("rst2_cfg_out", 32'(bif.cfg_out), 32'd0);
        check("rst2_valid", 32'(bif.bus_valid), 32'd0);
        check("rst2_err", 32'(bif.err_sticky), 32'd0);
        shift_cfg(8'b0100_0000, 8'h00, 1'b1);
        commit();
        settle();
        check("drv3_bus", 32'(bus), 32'hC);

`ifdef TBUF_BUS_KEEPER_EN
        shift_cfg(8'b0011_0000, 8'b0100_0000, 1'b1);
        commit();
        bif.drv_oe = 4'b0100;
        settle();
        check("keep_drive", 32'(bus), 32'h7);
        tick();
        bif.drv_oe = 4'b0000;
        settle();
        check("keep_hold", 32'(bus), 32'h7);
        check("keep_valid", 32'(bif.bus_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("keep_rst", 32'(bus), 32'h0);
`endif

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
